// File: rtl/eth_type_demux.sv
// eth_type_demux: routes each Ethernet frame (header + payload stream) to one
// of M_COUNT output channels by EtherType, using a runtime-programmable match
// table. Frames with no match are consumed and dropped.
// The header outputs are registered. The payload path is a zero-latency
// combinational pass-through to the selected channel.
// Optional feature macro: ETH_DEMUX_STATS_EN adds saturating per-channel
// frame counters and a dropped-frame counter.
module eth_type_demux #(
    parameter int M_COUNT    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_eth_hdr_valid,
    output logic                      s_eth_hdr_ready,
    input  logic [47:0]               s_eth_dest_mac,
    input  logic [47:0]               s_eth_src_mac,
    input  logic [15:0]               s_eth_type,
    input  logic [DATA_WIDTH-1:0]     s_eth_payload_axis_tdata,
    input  logic                      s_eth_payload_axis_tvalid,
    output logic                      s_eth_payload_axis_tready,
    input  logic                      s_eth_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0]     s_eth_payload_axis_tuser,
    input  logic [M_COUNT*16-1:0]     match_type,
    input  logic [M_COUNT-1:0]        match_enable,
    output logic [M_COUNT-1:0]        m_eth_hdr_valid,
    input  logic [M_COUNT-1:0]        m_eth_hdr_ready,
    output logic [47:0]               m_eth_dest_mac,
    output logic [47:0]               m_eth_src_mac,
    output logic [15:0]               m_eth_type,
    output logic [DATA_WIDTH-1:0]     m_eth_payload_axis_tdata,
    output logic [USER_WIDTH-1:0]     m_eth_payload_axis_tuser,
    output logic [M_COUNT-1:0]        m_eth_payload_axis_tvalid,
    input  logic [M_COUNT-1:0]        m_eth_payload_axis_tready,
    output logic                      m_eth_payload_axis_tlast,
    output logic                      busy
`ifdef ETH_DEMUX_STATS_EN
    ,
    output logic [M_COUNT*CNT_WIDTH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0]         stat_drops
`endif
);

    localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HDR     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    // Saturating increment used by the statistics counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [SEL_W-1:0]   sel_r;
    logic [SEL_W-1:0]   hit_idx_s;
    logic               hit_s;
    logic               hdr_fire_s;
    logic               last_fire_s;
    logic [M_COUNT-1:0] hdr_valid_r;
    logic               hdr_ready_r;
    logic               busy_r;
    logic [47:0]        dest_r;
    logic [47:0]        src_r;
    logic [15:0]        type_r;

    assign hdr_fire_s  = (state_r == ST_IDLE) && s_eth_hdr_valid;
    assign last_fire_s = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready
                         && s_eth_payload_axis_tlast;

    assign s_eth_hdr_ready = hdr_ready_r;
    assign busy            = busy_r;
    assign m_eth_hdr_valid = hdr_valid_r;
    assign m_eth_dest_mac  = dest_r;
    assign m_eth_src_mac   = src_r;
    assign m_eth_type      = type_r;

    // Table lookup: scan downwards so the lowest matching enabled index wins.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = M_COUNT - 1; i >= 0; i--) begin
            if (match_enable[i] && (match_type[16*i +: 16] == s_eth_type)) begin
                hit_s     = 1'b1;
                hit_idx_s = SEL_W'(i);
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Payload steering: pass-through to the selected channel, sink in DROP.
    always_comb begin
        s_eth_payload_axis_tready = 1'b0;
        m_eth_payload_axis_tvalid = '0;
        m_eth_payload_axis_tdata  = '0;
        m_eth_payload_axis_tuser  = '0;
        m_eth_payload_axis_tlast  = 1'b0;
        case (state_r)
            ST_PAYLOAD: begin
                s_eth_payload_axis_tready = m_eth_payload_axis_tready[sel_r];
                m_eth_payload_axis_tvalid = M_COUNT'(s_eth_payload_axis_tvalid) << sel_r;
                m_eth_payload_axis_tdata  = s_eth_payload_axis_tdata;
                m_eth_payload_axis_tuser  = s_eth_payload_axis_tuser;
                m_eth_payload_axis_tlast  = s_eth_payload_axis_tlast;
            end
            ST_DROP: begin
                s_eth_payload_axis_tready = 1'b1;
            end
            default: begin
                s_eth_payload_axis_tready = 1'b0;
            end
        endcase
    end

    // Next-state logic for the per-frame routing FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (s_eth_hdr_valid) begin
                    state_nxt_s = hit_s ? ST_HDR : ST_DROP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (m_eth_hdr_ready[sel_r]) begin
                    state_nxt_s = ST_PAYLOAD;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
            ST_PAYLOAD, ST_DROP: begin
                if (last_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state plus the status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            hdr_ready_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hdr_ready_r <= (state_nxt_s == ST_IDLE);
            busy_r      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Header capture: fields and channel select are frozen for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r  <= '0;
            dest_r <= 48'd0;
            src_r  <= 48'd0;
            type_r <= 16'd0;
        end else if (hdr_fire_s) begin
            sel_r  <= hit_idx_s;
            dest_r <= s_eth_dest_mac;
            src_r  <= s_eth_src_mac;
            type_r <= s_eth_type;
        end else begin
            sel_r  <= sel_r;
            dest_r <= dest_r;
            src_r  <= src_r;
            type_r <= type_r;
        end
    end

    // Per-channel header valid: raised one cycle after acceptance, held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_valid_r <= '0;
        end else if (hdr_fire_s && hit_s) begin
            hdr_valid_r <= M_COUNT'(1'b1) << hit_idx_s;
        end else if ((state_r == ST_HDR) && !m_eth_hdr_ready[sel_r]) begin
            hdr_valid_r <= hdr_valid_r;
        end else begin
            hdr_valid_r <= '0;
        end
    end

`ifdef ETH_DEMUX_STATS_EN
    // Saturating counters for delivered frames per channel and dropped frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames <= '0;
            stat_drops  <= '0;
        end else if (last_fire_s && (state_r == ST_PAYLOAD)) begin
            stat_frames[sel_r*CNT_WIDTH +: CNT_WIDTH] <=
                sat_inc(stat_frames[sel_r*CNT_WIDTH +: CNT_WIDTH]);
        end else if (last_fire_s && (state_r == ST_DROP)) begin
            stat_drops <= sat_inc(stat_drops);
        end else begin
            stat_frames <= stat_frames;
            stat_drops  <= stat_drops;
        end
    end
`endif

endmodule

// File: tb/tb_eth_type_demux.sv
// Self-checking bench for eth_type_demux (M_COUNT=2). Random frames are routed
// by a reference model that applies the lowest-enabled-match rule directly.
module tb_eth_type_demux;

    localparam int M  = 2;
    localparam int DW = 8;
    localparam int UW = 1;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_eth_hdr_valid;
    logic          s_eth_hdr_ready;
    logic [47:0]   s_eth_dest_mac;
    logic [47:0]   s_eth_src_mac;
    logic [15:0]   s_eth_type;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [UW-1:0] s_tuser;
    logic [M*16-1:0] match_type;
    logic [M-1:0]  match_enable;
    logic [M-1:0]  m_eth_hdr_valid;
    logic [M-1:0]  m_eth_hdr_ready;
    logic [47:0]   m_eth_dest_mac;
    logic [47:0]   m_eth_src_mac;
    logic [15:0]   m_eth_type;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic [M-1:0]  m_tvalid;
    logic [M-1:0]  m_tready;
    logic          m_tlast;
    logic          busy;
`ifdef ETH_DEMUX_STATS_EN
    logic [M*CW-1:0] stat_frames;
    logic [CW-1:0]   stat_drops;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_frames [M];
    int exp_drops  = 0;

    eth_type_demux #(.M_COUNT(M), .DATA_WIDTH(DW), .USER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .s_eth_hdr_valid           (s_eth_hdr_valid),
        .s_eth_hdr_ready           (s_eth_hdr_ready),
        .s_eth_dest_mac            (s_eth_dest_mac),
        .s_eth_src_mac             (s_eth_src_mac),
        .s_eth_type                (s_eth_type),
        .s_eth_payload_axis_tdata  (s_tdata),
        .s_eth_payload_axis_tvalid (s_tvalid),
        .s_eth_payload_axis_tready (s_tready),
        .s_eth_payload_axis_tlast  (s_tlast),
        .s_eth_payload_axis_tuser  (s_tuser),
        .match_type                (match_type),
        .match_enable              (match_enable),
        .m_eth_hdr_valid           (m_eth_hdr_valid),
        .m_eth_hdr_ready           (m_eth_hdr_ready),
        .m_eth_dest_mac            (m_eth_dest_mac),
        .m_eth_src_mac             (m_eth_src_mac),
        .m_eth_type                (m_eth_type),
        .m_eth_payload_axis_tdata  (m_tdata),
        .m_eth_payload_axis_tuser  (m_tuser),
        .m_eth_payload_axis_tvalid (m_tvalid),
        .m_eth_payload_axis_tready (m_tready),
        .m_eth_payload_axis_tlast  (m_tlast),
        .busy                      (busy)
`ifdef ETH_DEMUX_STATS_EN
        ,
        .stat_frames               (stat_frames),
        .stat_drops                (stat_drops)
`endif
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference routing rule: lowest enabled entry whose type equals etype, else -1.
    function automatic int route(input logic [15:0] etype, input logic [M*16-1:0] tbl,
                                 input logic [M-1:0] en);
        for (int i = 0; i < M; i++) begin
            if (en[i] && tbl[16*i +: 16] == etype) return i;
        end
        return -1;
    endfunction

    task automatic check_stats();
`ifdef ETH_DEMUX_STATS_EN
        for (int i = 0; i < M; i++) check("stat_frames", stat_frames[i*CW +: CW], 64'(exp_frames[i]));
        check("stat_drops", stat_drops, 64'(exp_drops));
`endif
    endtask

    // Send one frame; hold = cycles of header back-pressure; retable swaps the
    // table right after acceptance; abort_at >= 0 pulses rst_n at that byte.
    task automatic send_frame(input logic [15:0] etype, input int len, input int hold,
                              input bit retable, input int abort_at);
        logic [7:0]  data [64];
        logic [0:0]  usr  [64];
        logic [47:0] dmac, smac;
        logic [1:0]  oh;
        logic [1:0]  rdy;
        logic        vld;
        int ch, k, cyc;
        for (int i = 0; i < len; i++) begin
            data[i] = 8'($urandom);
            usr[i]  = 1'($urandom);
        end
        dmac = {16'($urandom), 32'($urandom)};
        smac = {16'($urandom), 32'($urandom)};
        @(negedge clk);
        s_eth_hdr_valid = 1'b1;
        s_eth_dest_mac  = dmac;
        s_eth_src_mac   = smac;
        s_eth_type      = etype;
        s_tvalid        = 1'b0;
        #1;
        check("hdr_ready_idle", s_eth_hdr_ready, 1);
        check("hdr_valid_pre", m_eth_hdr_valid, 0);
        ch = route(etype, match_type, match_enable);
        oh = (ch >= 0) ? (2'b01 << ch) : 2'b00;
        @(posedge clk);
        @(negedge clk);
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac  = {16'($urandom), 32'($urandom)};
        s_eth_src_mac   = {16'($urandom), 32'($urandom)};
        s_eth_type      = 16'($urandom);
        if (retable) match_type = {match_type[15:0], match_type[31:16]};
        if (ch >= 0) begin
            for (int h = 0; h <= hold; h++) begin
                if (h > 0) @(negedge clk);
                m_eth_hdr_ready = (h == hold) ? (2'($urandom) | oh) : (2'($urandom) & ~oh);
                s_tvalid = 1'b1;
                s_tdata  = data[0];
                s_tlast  = (len == 1);
                m_tready = 2'($urandom);
                #1;
                check("hdr_valid", m_eth_hdr_valid, 64'(oh));
                check("hdr_dest", m_eth_dest_mac, dmac);
                check("hdr_src", m_eth_src_mac, smac);
                check("hdr_type", m_eth_type, etype);
                check("hdr_tready", s_tready, 0);
                check("hdr_tvalid", m_tvalid, 0);
                check("hdr_busy", busy, 1);
                @(posedge clk);
            end
        end
        k = 0;
        cyc = 0;
        while (k < len && cyc < 400) begin
            cyc++;
            @(negedge clk);
            m_eth_hdr_ready = 2'($urandom);
            vld = ($urandom_range(3, 0) != 0);
            rdy = 2'($urandom) | ((cyc % 3 == 0) ? oh : 2'b00);
            s_tvalid = vld;
            s_tdata  = data[k];
            s_tuser  = usr[k];
            s_tlast  = (k == len - 1);
            m_tready = rdy;
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_tvalid", m_tvalid, 0);
                check("abort_hvalid", m_eth_hdr_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_hready", s_eth_hdr_ready, 1);
                check("abort_tready", s_tready, 0);
                @(posedge clk);
                @(negedge clk);
                rst_n    = 1'b1;
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                for (int i = 0; i < M; i++) exp_frames[i] = 0;
                exp_drops = 0;
                return;
            end
            #1;
            check("pay_hvalid", m_eth_hdr_valid, 0);
            check("pay_busy", busy, 1);
            if (ch >= 0) begin
                check("pay_tvalid", m_tvalid, vld ? 64'(oh) : 64'd0);
                check("pay_tready", s_tready, 64'(rdy[ch]));
                if (vld && rdy[ch]) begin
                    check("pay_tdata", m_tdata, data[k]);
                    check("pay_tuser", m_tuser, usr[k]);
                    check("pay_tlast", m_tlast, 64'(k == len - 1));
                end
                @(posedge clk);
                if (vld && rdy[ch]) k++;
            end else begin
                check("drop_tready", s_tready, 1);
                check("drop_tvalid", m_tvalid, 0);
                @(posedge clk);
                if (vld) k++;
            end
        end
        if (k < len) check("payload_timeout", 64'(k), 64'(len));
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        check("end_busy", busy, 0);
        check("end_hready", s_eth_hdr_ready, 1);
        check("end_hvalid", m_eth_hdr_valid, 0);
        check("end_tvalid", m_tvalid, 0);
        if (ch >= 0) exp_frames[ch]++;
        else exp_drops++;
    endtask

    initial begin
        logic [15:0] pool [4];
        pool[0] = 16'h0800; pool[1] = 16'h0806; pool[2] = 16'h86DD; pool[3] = 16'h88CC;
        for (int i = 0; i < M; i++) exp_frames[i] = 0;
        rst_n = 1'b0;
        s_eth_hdr_valid = 1'b0;
        s_eth_dest_mac = 48'd0;
        s_eth_src_mac = 48'd0;
        s_eth_type = 16'd0;
        s_tdata = 8'd0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tuser = 1'b0;
        m_eth_hdr_ready = 2'b00;
        m_tready = 2'b00;
        match_type = {16'h0800, 16'h0806};
        match_enable = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_hready", s_eth_hdr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_hvalid", m_eth_hdr_valid, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tready", s_tready, 0);
        check("rst_dest", m_eth_dest_mac, 0);
        check("rst_type", m_eth_type, 0);
        check("rst_tdata", m_tdata, 0);
        check_stats();
        rst_n = 1'b1;

        send_frame(16'h0800, 20, 0, 1'b0, -1);
        send_frame(16'h86DD, 30, 0, 1'b0, -1);
        check_stats();
        send_frame(16'h0800, 8, 5, 1'b0, -1);
        match_type = {16'h0800, 16'h0800};
        send_frame(16'h0800, 6, 1, 1'b0, -1);
        match_enable = 2'b10;
        send_frame(16'h0800, 6, 0, 1'b0, -1);
        match_enable = 2'b00;
        send_frame(16'h0800, 5, 0, 1'b0, -1);
        match_type = {16'h0800, 16'h0806};
        match_enable = 2'b11;
        send_frame(16'h0800, 12, 1, 1'b1, -1);
        send_frame(16'h0800, 4, 0, 1'b0, -1);
        check_stats();
        match_type = {16'h0800, 16'h0806};
        send_frame(16'h0800, 16, 0, 1'b0, 7);
        check_stats();
        send_frame(16'h0806, 10, 2, 1'b0, -1);
        send_frame(16'h0800, 1, 0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            match_type   = {pool[$urandom_range(3, 0)], pool[$urandom_range(3, 0)]};
            match_enable = 2'($urandom);
            send_frame(pool[$urandom_range(3, 0)], $urandom_range(24, 1), $urandom_range(3, 0),
                       1'($urandom), -1);
        end
        check_stats();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
